// File: rtl/da_barrel_seq_ctrl.sv
// Sequencer for the four-lane DA barrel datapath: primes the delay register, steps t over every bit slice and accumulates one lane.
// Optional abort input is compiled in when DA_SEQ_ABORT_EN is defined.
module da_barrel_seq_ctrl #(
  parameter int BITS  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       lane_sel,
  input  logic [7:0]       y2,
  input  logic [7:0]       y3,
  input  logic [7:0]       y4,
  input  logic [7:0]       y5,
`ifdef DA_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       t,
  output logic             sign,
  output logic             slice_vld,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [2:0] K_LAST = 3'(BITS - 1);

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [1:0]         lane_q, lane_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic [7:0]         y_sel;
  logic [ACC_W-1:0]   y_ext;
  logic               abort_req;

`ifdef DA_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    y_sel = y2;
    case (lane_q)
      2'd0:    y_sel = y2;
      2'd1:    y_sel = y3;
      2'd2:    y_sel = y4;
      default: y_sel = y5;
    endcase
  end

  assign y_ext = {{(ACC_W - 8){y_sel[7]}}, y_sel};

  // The MSB slice carries negative weight in two's complement, so it is subtracted.
  // result is loaded on the last RUN edge so it is already valid while done is high.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
          lane_d  = lane_sel;
          acc_d   = '0;
          k_d     = 3'd0;
        end
      end
      S_PRIME: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          acc_d    = acc_q - y_ext;
          result_d = acc_q - y_ext;
          k_d      = 3'd0;
          state_d  = S_FIN;
        end else begin
          acc_d = acc_q + y_ext;
          k_d   = k_q + 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_req && (state_q == S_PRIME || state_q == S_RUN)) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      k_d      = 3'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= 3'd0;
      lane_q   <= 2'd0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    t         = 3'd0;
    sign      = 1'b0;
    slice_vld = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    if (state_q == S_RUN) begin
      t         = k_q;
      sign      = (k_q == K_LAST);
      slice_vld = 1'b1;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_da_barrel_seq_ctrl.sv
// Self-checking bench for da_barrel_seq_ctrl: random lane data against a weighted-sum model of two's-complement DA.
// Abort scenario is exercised only when DA_SEQ_ABORT_EN is defined.
module tb_da_barrel_seq_ctrl;

  localparam int BITS  = 8;
  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       lane_sel = 2'd0;
  logic [7:0]       y2 = 8'd0;
  logic [7:0]       y3 = 8'd0;
  logic [7:0]       y4 = 8'd0;
  logic [7:0]       y5 = 8'd0;
`ifdef DA_SEQ_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic [2:0]       t;
  logic             sign;
  logic             slice_vld;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;

  int               checks = 0;
  int               errors = 0;
  logic [ACC_W-1:0] exp_result = '0;

  da_barrel_seq_ctrl #(.BITS(BITS), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .lane_sel(lane_sel),
    .y2(y2),
    .y3(y3),
    .y4(y4),
    .y5(y5),
`ifdef DA_SEQ_ABORT_EN
    .abort(abort),
`endif
    .t(t),
    .sign(sign),
    .slice_vld(slice_vld),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic drive_lanes(input bit rnd, input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] f2, input logic [7:0] f3);
    if (rnd) begin
      y2 = 8'($urandom);
      y3 = 8'($urandom);
      y4 = 8'($urandom);
      y5 = 8'($urandom);
    end else begin
      y2 = f0;
      y3 = f1;
      y4 = f2;
      y5 = f3;
    end
  endtask

  function automatic logic [7:0] lane_val(input logic [1:0] l);
    case (l)
      2'd0:    return y2;
      2'd1:    return y3;
      2'd2:    return y4;
      default: return y5;
    endcase
  endfunction

  // Inputs are driven and outputs sampled on the falling edge; one full operation from its IDLE cycle to FIN.
  task automatic run_op(input logic [1:0] lane, input bit rnd,
                        input logic [7:0] f0, input logic [7:0] f1,
                        input logic [7:0] f2, input logic [7:0] f3, input bit hold);
    int acc;
    int v;
    @(negedge clk);
    checks++;
    if ({busy, done, slice_vld, sign, t} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL idle_ctrl got busy=%b done=%b vld=%b sign=%b t=%0d want all 0",
               busy, done, slice_vld, sign, t);
    end
    checks++;
    if (result !== exp_result) begin
      errors++;
      $display("[TB] FAIL idle_result_hold got %h want %h", result, exp_result);
    end
    start    = 1'b1;
    lane_sel = lane;
    drive_lanes(rnd, f0, f1, f2, f3);

    @(negedge clk);
    if (!hold) start = 1'b0;
    lane_sel = 2'($urandom);
    checks++;
    if ({busy, done, slice_vld, sign, t} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL prime_ctrl got busy=%b done=%b vld=%b sign=%b t=%0d want busy=1 rest 0",
               busy, done, slice_vld, sign, t);
    end
    drive_lanes(rnd, f0, f1, f2, f3);

    acc = 0;
    for (int k = 0; k < BITS; k++) begin
      @(negedge clk);
      checks++;
      if (t !== 3'(k) || sign !== (k == BITS - 1) || slice_vld !== 1'b1 ||
          busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_k%0d_ctrl got t=%0d sign=%b vld=%b busy=%b done=%b want t=%0d sign=%b vld=1 busy=1 done=0",
                 k, t, sign, slice_vld, busy, done, k, (k == BITS - 1));
      end
      drive_lanes(rnd, f0, f1, f2, f3);
      v = int'($signed(lane_val(lane)));
      acc += (k == BITS - 1) ? -v : v;
    end

    @(negedge clk);
    exp_result = ACC_W'(acc);
    checks++;
    if ({busy, done, slice_vld, sign, t} !== 7'b1100000) begin
      errors++;
      $display("[TB] FAIL fin_ctrl got busy=%b done=%b vld=%b sign=%b t=%0d want busy=1 done=1 rest 0",
               busy, done, slice_vld, sign, t);
    end
    checks++;
    if (result !== exp_result) begin
      errors++;
      $display("[TB] FAIL fin_result lane=%0d got %h want %h", lane, result, exp_result);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, slice_vld, sign, t, result} !== 23'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b vld=%b sign=%b t=%0d result=%h want all 0",
               busy, done, slice_vld, sign, t, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL reset_idle_%0d got busy=%b done=%b result=%h want 0 0 0000",
                 i, busy, done, result);
      end
    end
    exp_result = '0;
  endtask

  task automatic test_basic();
    run_op(2'd0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (result !== 16'h0012) begin
      errors++;
      $display("[TB] FAIL basic_result got %h want 0012", result);
    end
  endtask

  task automatic test_lane_select();
    run_op(2'd2, 1'b0, 8'h7F, 8'h11, 8'hFE, 8'h22, 1'b0);
    checks++;
    if (result !== 16'hFFF4) begin
      errors++;
      $display("[TB] FAIL lane2_result got %h want fff4", result);
    end
    run_op(2'd2, 1'b0, 8'h81, 8'h33, 8'hFE, 8'h44, 1'b0);
    checks++;
    if (result !== 16'hFFF4) begin
      errors++;
      $display("[TB] FAIL lane2_y2_indep got %h want fff4", result);
    end
  endtask

  // start stays high through the whole operation: it must neither restart nor produce an extra done.
  task automatic test_boundary();
    run_op(2'd1, 1'b0, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1);
    checks++;
    if (result !== 16'hFD00) begin
      errors++;
      $display("[TB] FAIL boundary_result got %h want fd00", result);
    end
  endtask

  task automatic test_back_to_back();
    run_op(2'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    run_op(2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start    = 1'b1;
    lane_sel = 2'd0;
    y2       = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (t !== 3'd4 || slice_vld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_k4 got t=%0d vld=%b want 4 1", t, slice_vld);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || t !== 3'd0 || result !== 16'h0000 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset got busy=%b t=%0d result=%h done=%b want 0 0 0000 0",
               busy, t, result, done);
    end
    rst        = 1'b0;
    exp_result = '0;
    run_op(2'd1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(2'($urandom), 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== exp_result) begin
      errors++;
      $display("[TB] FAIL random_tail got busy=%b result=%h want 0 %h", busy, result, exp_result);
    end
  endtask

`ifdef DA_SEQ_ABORT_EN
  task automatic test_abort();
    run_op(2'd0, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    lane_sel = 2'd1;
    drive_lanes(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0012) begin
      errors++;
      $display("[TB] FAIL abort_state got busy=%b done=%b result=%h want 0 0 0012",
               busy, done, result);
    end
    exp_result = 16'h0012;
    run_op(2'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lane_select();
    test_boundary();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
`ifdef DA_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/da_barrel_seq_ctrl.md
Name: da_barrel_seq_ctrl

Overview:
Sequencer for the four-lane rotate/delay/add-subtract barrel datapath of the DA-based LMS filter.
- Per request, steps the rotate amount `t` through every bit slice and asserts `sign` (subtract) on the MSB slice, for two's-complement DA.
- Primes the datapath's one-cycle delay register, accumulates one selected lane output into a wide result, and reports completion on a start/busy/done handshake.
- Sits between the filter top-level control and the barrel datapath.

Parameters:
- BITS, 8, number of bit slices per operation; legal range 2..8 (fits the 3-bit `t`).
- ACC_W, 16, accumulator/result width; must be ≥ 8 + clog2(BITS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- lane_sel  input  2  lane to accumulate (0..3 = y2..y5); captured when start is accepted.
- y2  input  8  datapath lane 0 output, signed.
- y3  input  8  datapath lane 1 output, signed.
- y4  input  8  datapath lane 2 output, signed.
- y5  input  8  datapath lane 3 output, signed.
- t  output  3  rotate amount driven to the datapath.
- sign  output  1  1 = datapath subtracts, 0 = adds.
- slice_vld  output  1  high in cycles whose lane output is accumulated.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  ACC_W  signed accumulated result; held until the next done.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - State IDLE; t=0, sign=0, slice_vld=0, busy=0, done=0, result=0, accumulator=0, slice counter=0.
  - Reset mid-operation aborts immediately with the same values; no done pulse is issued.
- States: IDLE, PRIME, RUN, FIN.
- IDLE:
  - Outputs t=0, sign=0.
  - start=1 → PRIME; lane_sel is latched, accumulator cleared, slice counter=0.
  - start=0 → remain in IDLE.
- PRIME (exactly 1 cycle):
  - t=0, sign=0, slice_vld=0, busy=1. Loads the datapath delay register; the lane output is ignored.
  - Next state RUN.
- RUN (exactly BITS cycles, slice counter k = 0..BITS-1):
  - t=k, slice_vld=1, busy=1. sign=1 only when k=BITS-1, else 0.
  - Accumulator update:
    - k<BITS-1: acc += sext(y_sel).
    - k=BITS-1: acc −= sext(y_sel).
  - After k=BITS-1 → FIN.
- FIN (1 cycle):
  - done=1, busy=1, result←final accumulator, t=0, sign=0, slice_vld=0.
  - Next state IDLE.
- Latency: start accepted at edge N → PRIME in cycle N+1, RUN in N+2..N+BITS+1, done in N+BITS+2.
- start while not in IDLE is ignored (not queued). start in the same cycle done is asserted is also ignored.
- Back-to-back: start held continuously → a new operation is accepted on the IDLE cycle immediately after FIN.
- Arithmetic:
  - Lanes are sign-extended to ACC_W.
  - Accumulator wraps modulo 2^ACC_W; no saturation.
  - lane_sel changes after acceptance have no effect.
- t never exceeds BITS-1.

Optional Feature:
- Macro: DA_SEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in PRIME or RUN → next state IDLE.
  - busy=0 next cycle; no done pulse; result keeps its previous value; accumulator cleared.
  - abort in IDLE or FIN has no effect. abort has priority over the state transition in the same cycle; rst has priority over abort.
- Undefined: no `abort` port; operations always run to completion.

Test Plan:
- Reset: rst=1 for 2 cycles, then start=0 → all outputs 0, state IDLE; busy stays 0 for 5 idle cycles.
- Basic op, BITS=8: lane_sel=0, y2 held at 3, start pulse → t steps 0..7 over cycles N+2..N+9; sign=1 only at t=7; done at N+10; result=0x0012 (7×3−3).
- Lane selection: lane_sel=2, y4=−2 (0xFE), y2=0x7F → result=−12 (0xFFF4); y2 does not affect the result.
- Boundary: y_sel=0x80 constant → result=7×(−128)+128=−768 (0xFD00). start during busy → no restart, and exactly one done pulse occurs.
- Reset mid-op: rst at RUN slice k=4 → next cycle busy=0, t=0, result=0, no done. A new start then completes normally in 10 cycles.
- Abort (DA_SEQ_ABORT_EN defined): abort at k=3 after a previous result=0x0012 → IDLE, no done, result stays 0x0012; the next start works normally.
